// File: rtl/tm1638_seq_pkg.sv
// Shared definitions for the TM1638 frame sequencer: command bytes, segment table, FSM states.
package tm1638_seq_pkg;

   localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
   localparam logic [7:0] CMD_ADDR0     = 8'hC0;
   localparam logic [7:0] CMD_DISP_ON   = 8'h88;
   localparam logic [7:0] CMD_DISP_OFF  = 8'h80;

   localparam logic [4:0] C2_LAST_BYTE = 5'd16;
   localparam logic [1:0] TX_LAST      = 2'd2;

   // bit0 = segment a .. bit6 = g, dp always off; codes 10..15 blank
   localparam logic [7:0] SEG7_TBL [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STB_SETUP,
      S_BIT_LO,
      S_BIT_HI,
      S_STB_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/tm1638_seq_seg7_enc.sv
// BCD digit to 7-segment pattern, purely combinational.
module seg7_enc
   import tm1638_seq_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG7_TBL[bcd];
   end

endmodule

// File: rtl/tm1638_seq.sv
// TM1638 display frame sequencer: sends the 40 / C0+16 bytes / 8x command set
// over the STB/CLK/DIO serial link, LSB first.
module tm1638_seq
   import tm1638_seq_pkg::*;
#(
   parameter int unsigned HALF_T = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] digits,
   input  logic [2:0]  bright,
   input  logic        disp_on,
   output logic        busy,
   output logic        done,
   output logic        tm_clk,
   output logic        tm_stb,
   output logic        tm_dio
);

   localparam logic [7:0] HALF_LAST = 8'(HALF_T - 1);

   state_t      state, state_nxt;
   logic [2:0]  bit_idx;
   logic [4:0]  byte_idx;
   logic [1:0]  tx_idx;
   logic [7:0]  timer;
   logic [31:0] snap_digits;
   logic [2:0]  snap_bright;
   logic        snap_disp_on;

   logic        half_done, last_bit, last_byte, last_tx;
   logic [3:0]  data_idx;
   logic [3:0]  cur_digit;
   logic [7:0]  cur_seg;
   logic [7:0]  cur_byte;

   assign half_done = (timer == HALF_LAST);
   assign last_bit  = (bit_idx == 3'd7);
   assign last_byte = (tx_idx == 2'd1) ? (byte_idx == C2_LAST_BYTE) : (byte_idx == 5'd0);
   assign last_tx   = (tx_idx == TX_LAST);
   assign data_idx  = byte_idx[3:0] - 4'd1;

   always_comb begin
      cur_digit = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (data_idx[3:1] == 3'(k)) cur_digit = snap_digits[4*k +: 4];
      end
   end

   seg7_enc u_seg7_enc (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   always_comb begin
      case (tx_idx)
         2'd0:    cur_byte = CMD_DATA_AUTO;
         2'd1:    cur_byte = (byte_idx == 5'd0) ? CMD_ADDR0 : (data_idx[0] ? '0 : cur_seg);
         2'd2:    cur_byte = snap_disp_on ? (CMD_DISP_ON | {5'b0, snap_bright}) : CMD_DISP_OFF;
         default: cur_byte = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (start) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_STB_SETUP;
         S_STB_SETUP: if (half_done) state_nxt = S_BIT_LO;
         S_BIT_LO:    if (half_done) state_nxt = S_BIT_HI;
         S_BIT_HI:    if (half_done) state_nxt = (last_bit && last_byte) ? S_STB_GAP : S_BIT_LO;
         S_STB_GAP:   if (half_done && bit_idx[0]) state_nxt = last_tx ? S_DONE : S_STB_SETUP;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      tm_stb = 1'b1;
      tm_clk = 1'b1;
      tm_dio = 1'b1;
      case (state)
         S_LOAD:      busy = 1'b1;
         S_STB_SETUP: begin busy = 1'b1; tm_stb = 1'b0; end
         S_BIT_LO:    begin busy = 1'b1; tm_stb = 1'b0; tm_clk = 1'b0; tm_dio = cur_byte[bit_idx]; end
         S_BIT_HI:    begin busy = 1'b1; tm_stb = 1'b0; tm_dio = cur_byte[bit_idx]; end
         S_STB_GAP:   busy = 1'b1;
         S_DONE:      done = 1'b1;
         default:     ;
      endcase
   end

   // The gap spans two half-bit periods; bit_idx (idle at 0 there) tracks which half.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_idx      <= '0;
         byte_idx     <= '0;
         tx_idx       <= '0;
         timer        <= '0;
         snap_digits  <= '0;
         snap_bright  <= '0;
         snap_disp_on <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            snap_digits  <= digits;
            snap_bright  <= bright;
            snap_disp_on <= disp_on;
         end
         case (state)
            S_STB_SETUP, S_BIT_LO, S_BIT_HI, S_STB_GAP:
               timer <= half_done ? '0 : timer + 8'd1;
            default:
               timer <= '0;
         endcase
         case (state)
            S_IDLE: begin
               bit_idx  <= '0;
               byte_idx <= '0;
               tx_idx   <= '0;
            end
            S_BIT_HI: if (half_done) begin
               bit_idx <= bit_idx + 3'd1;
               if (last_bit) byte_idx <= last_byte ? '0 : byte_idx + 5'd1;
            end
            S_STB_GAP: if (half_done) begin
               bit_idx <= bit_idx[0] ? 3'd0 : 3'd1;
               if (bit_idx[0]) tx_idx <= last_tx ? '0 : tx_idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
